// File: rtl/bram_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them to block RAM,
// holding the CPU in reset until the image is loaded. Optional readback check: LOADER_READBACK_EN.
// Latency: 5 cycles/word (7 with readback). Backpressure: o_byte_ready low outside COLLECT.
module bram_loader #(
    parameter int              SIZE      = 14,
    parameter logic [SIZE-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [SIZE-1:0] i_word_count,
    input  logic            i_byte_valid,
    input  logic [7:0]      i_byte,
    output logic            o_byte_ready,
    output logic            o_we,
    output logic [SIZE-1:0] o_addr,
    output logic [31:0]     o_data,
    input  logic [31:0]     i_ram_data,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_cpu_rst,
    output logic            o_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
`ifdef LOADER_READBACK_EN
        RD      = 3'd3,
        CMP     = 3'd4,
`endif
        DONE    = 3'd5
    } state_t;

    state_t          state;
    logic [SIZE-1:0] remaining;
    logic [1:0]      byte_idx;
    logic [23:0]     shreg;

    logic start_acc;
    logic word_end;
    logic last_word;

    assign start_acc = i_start && (state == IDLE || state == DONE);
    assign last_word = (remaining == SIZE'(1));

`ifdef LOADER_READBACK_EN
    assign word_end = (state == CMP);
`else
    assign word_end = (state == WRITE);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            remaining    <= '0;
            byte_idx     <= '0;
            shreg        <= '0;
            o_we         <= 1'b0;
            o_addr       <= '0;
            o_data       <= '0;
            o_byte_ready <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_cpu_rst    <= 1'b1;
        end else begin
            o_we <= 1'b0;
            if (start_acc) begin
                remaining <= i_word_count;
                o_addr    <= BASE_ADDR;
                byte_idx  <= '0;
                if (i_word_count != '0) begin
                    state        <= COLLECT;
                    o_byte_ready <= 1'b1;
                    o_busy       <= 1'b1;
                    o_done       <= 1'b0;
                    o_cpu_rst    <= 1'b1;
                end else begin
                    state        <= DONE;
                    o_byte_ready <= 1'b0;
                    o_busy       <= 1'b0;
                    o_done       <= 1'b1;
                    o_cpu_rst    <= 1'b0;
                end
            end else begin
                case (state)
                    COLLECT: begin
                        if (i_byte_valid && o_byte_ready) begin
                            shreg    <= {shreg[15:0], i_byte};
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                o_data       <= {shreg, i_byte};
                                o_we         <= 1'b1;
                                o_byte_ready <= 1'b0;
                                state        <= WRITE;
                            end
                        end
                    end
`ifdef LOADER_READBACK_EN
                    WRITE:   state <= RD;
                    RD:      state <= CMP;
`endif
                    default: ;
                endcase
                // Address and word count advance once per word, after its last state.
                if (word_end) begin
                    o_addr    <= o_addr + SIZE'(1);
                    remaining <= remaining - SIZE'(1);
                    if (last_word) begin
                        state     <= DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_cpu_rst <= 1'b0;
                    end else begin
                        state        <= COLLECT;
                        o_byte_ready <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef LOADER_READBACK_EN
    // The RAM has returned the word written two cycles earlier by the time we sit in CMP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_err <= 1'b0;
        end else if (start_acc) begin
            o_err <= 1'b0;
        end else if (state == CMP && i_ram_data != o_data) begin
            o_err <= 1'b1;
        end
    end
`else
    logic unused_ram_data;
    assign unused_ram_data = ^i_ram_data;
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: table of loads on a SIZE=14 instance, plus reset, wrap and readback sequences.
module tb_bram_loader;

`ifdef LOADER_READBACK_EN
    localparam int  PER     = 7;
    localparam bit  RB      = 1'b1;
`else
    localparam int  PER     = 5;
    localparam bit  RB      = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        byte_valid = 1'b0;
    logic [7:0]  byte_dat   = 8'h00;

    logic        m_start = 1'b0;
    logic [13:0] m_count = '0;
    logic        m_rdy, m_we, m_busy, m_done, m_cpu_rst, m_err;
    logic [13:0] m_addr;
    logic [31:0] m_data, m_rdata;

    logic        w_start = 1'b0;
    logic [3:0]  w_count = '0;
    logic        w_rdy, w_we, w_busy, w_done, w_cpu_rst, w_err;
    logic [3:0]  w_addr;
    logic [31:0] w_data, w_rdata;

    bram_loader u_main (
        .clk(clk), .rst(rst), .i_start(m_start), .i_word_count(m_count),
        .i_byte_valid(byte_valid), .i_byte(byte_dat), .o_byte_ready(m_rdy),
        .o_we(m_we), .o_addr(m_addr), .o_data(m_data), .i_ram_data(m_rdata),
        .o_busy(m_busy), .o_done(m_done), .o_cpu_rst(m_cpu_rst), .o_err(m_err)
    );

    bram_loader #(.SIZE(4), .BASE_ADDR(4'd15)) u_wrap (
        .clk(clk), .rst(rst), .i_start(w_start), .i_word_count(w_count),
        .i_byte_valid(byte_valid), .i_byte(byte_dat), .o_byte_ready(w_rdy),
        .o_we(w_we), .o_addr(w_addr), .o_data(w_data), .i_ram_data(w_rdata),
        .o_busy(w_busy), .o_done(w_done), .o_cpu_rst(w_cpu_rst), .o_err(w_err)
    );

    // RAM models with 1-cycle registered read; main one can corrupt one address on readback.
    logic [31:0] m_mem [0:16383];
    logic [31:0] w_mem [0:15];
    logic [13:0] m_log_a[$];
    logic [31:0] m_log_d[$];
    logic [3:0]  w_log_a[$];
    logic [31:0] w_log_d[$];
    logic        corrupt = 1'b0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_we) begin
            m_mem[m_addr] <= m_data;
            m_log_a.push_back(m_addr);
            m_log_d.push_back(m_data);
        end
        m_rdata <= m_mem[m_addr] ^ ((corrupt && m_addr == 14'd1) ? 32'h0000_0100 : 32'h0);
        if (w_we) begin
            w_mem[w_addr] <= w_data;
            w_log_a.push_back(w_addr);
            w_log_d.push_back(w_data);
        end
        w_rdata <= w_mem[w_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int start_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we"},      m_we,      0);
        chk({tag, "_addr"},    m_addr,    0);
        chk({tag, "_data"},    m_data,    0);
        chk({tag, "_rdy"},     m_rdy,     0);
        chk({tag, "_busy"},    m_busy,    0);
        chk({tag, "_done"},    m_done,    0);
        chk({tag, "_err"},     m_err,     0);
        chk({tag, "_cpu_rst"}, m_cpu_rst, 1);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_main(input logic [13:0] cnt);
        m_count = cnt;
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_bytes(input logic [63:0] bytes, input int n, input int gap, input bit to_wrap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
            byte_valid = 1'b1;
            byte_dat   = bytes[63 - 8*i -: 8];
            begin
                int t = 0;
                while (!(to_wrap ? w_rdy : m_rdy) && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 50) timeout("byte_ready");
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input bit on_wrap, output int dcyc);
        int t = 0;
        while (!(on_wrap ? w_done : m_done) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("done");
        dcyc = cyc;
    endtask

    typedef struct {
        logic [13:0] count;
        int          gap;
        logic [63:0] bytes;
        logic [31:0] exp0;
        logic [31:0] exp1;
        int          exp_we;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int dcyc;
        int base;

        vecs[0] = '{14'd2, 0, 64'h908c01f4_908c41f5, 32'h908c01f4, 32'h908c41f5, 2};
        vecs[1] = '{14'd2, 3, 64'h908c01f4_908c41f5, 32'h908c01f4, 32'h908c41f5, 2};
        vecs[2] = '{14'd1, 0, 64'h01020304_00000000, 32'h01020304, 32'h00000000, 1};
        vecs[3] = '{14'd2, 1, 64'hdeadbeef_00ff00ff, 32'hdeadbeef, 32'h00ff00ff, 2};
        vecs[4] = '{14'd0, 0, 64'h0,                 32'h00000000, 32'h00000000, 0};

        #1 rst = 1'b0;
        #3 check_reset("por");
        chk("por_wrap_cpu_rst", w_cpu_rst, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            base = m_log_a.size();
            start_main(vecs[v].count);
            chk($sformatf("v%0d_busy_after_start", v), m_busy, vecs[v].count != 0);
            chk($sformatf("v%0d_rdy_after_start", v),  m_rdy,  vecs[v].count != 0);
            if (vecs[v].count != 0) send_bytes(vecs[v].bytes, 4 * int'(vecs[v].count), vecs[v].gap, 1'b0);
            wait_done(1'b0, dcyc);
            if (vecs[v].gap == 0)
                chk($sformatf("v%0d_done_latency", v), dcyc - start_cyc, PER * int'(vecs[v].count));
            chk($sformatf("v%0d_we_count", v), m_log_a.size() - base, vecs[v].exp_we);
            if (vecs[v].exp_we >= 1 && m_log_a.size() > base) begin
                chk($sformatf("v%0d_addr0", v), m_log_a[base], 0);
                chk($sformatf("v%0d_word0", v), m_log_d[base], vecs[v].exp0);
            end
            if (vecs[v].exp_we >= 2 && m_log_a.size() > base + 1) begin
                chk($sformatf("v%0d_addr1", v), m_log_a[base+1], 1);
                chk($sformatf("v%0d_word1", v), m_log_d[base+1], vecs[v].exp1);
            end
            chk($sformatf("v%0d_done", v),    m_done,    1);
            chk($sformatf("v%0d_cpu_rst", v), m_cpu_rst, 0);
            chk($sformatf("v%0d_busy", v),    m_busy,    0);
            chk($sformatf("v%0d_err", v),     m_err,     0);
        end

        // Bytes offered while DONE must not be consumed.
        byte_valid = 1'b1;
        byte_dat   = 8'haa;
        repeat (3) @(negedge clk);
        base = m_log_a.size();
        start_main(14'd1);
        send_bytes(64'h11223344_00000000, 4, 0, 1'b0);
        wait_done(1'b0, dcyc);
        chk("idle_bytes_we_count", m_log_a.size() - base, 1);
        if (m_log_a.size() > base) chk("idle_bytes_word", m_log_d[base], 32'h11223344);

        // Address wrap on a 4-bit instance starting at 15.
        base = w_log_a.size();
        w_count = 4'd2;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        send_bytes(64'h0a0b0c0d_11223344, 8, 0, 1'b1);
        wait_done(1'b1, dcyc);
        chk("wrap_we_count", w_log_a.size() - base, 2);
        if (w_log_a.size() > base + 1) begin
            chk("wrap_addr0", w_log_a[base],   15);
            chk("wrap_word0", w_log_d[base],   32'h0a0b0c0d);
            chk("wrap_addr1", w_log_a[base+1], 0);
            chk("wrap_word1", w_log_d[base+1], 32'h11223344);
        end
        chk("wrap_cpu_rst", w_cpu_rst, 0);

        // Readback of word 1 corrupted by the RAM model.
        corrupt = 1'b1;
        base = m_log_a.size();
        start_main(14'd2);
        send_bytes(64'h908c01f4_908c41f5, 8, 0, 1'b0);
        wait_done(1'b0, dcyc);
        chk("rb_we_count", m_log_a.size() - base, 2);
        chk("rb_err_at_done", m_err, RB);
        chk("rb_done", m_done, 1);
        repeat (2) @(negedge clk);
        chk("rb_err_sticky", m_err, RB);
        corrupt = 1'b0;
        start_main(14'd0);
        chk("rb_err_cleared", m_err, 0);

        // Reset in the middle of the second word, then a clean one-word load.
        start_main(14'd2);
        send_bytes(64'hcafef00d_77000000, 5, 0, 1'b0);
        chk("midload_busy", m_busy, 1);
        chk("midload_cpu_rst", m_cpu_rst, 1);
        rst = 1'b0;
        #1 check_reset("midload_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base = m_log_a.size();
        start_main(14'd1);
        send_bytes(64'h55667788_00000000, 4, 0, 1'b0);
        wait_done(1'b0, dcyc);
        chk("post_rst_we_count", m_log_a.size() - base, 1);
        if (m_log_a.size() > base) begin
            chk("post_rst_addr", m_log_a[base], 0);
            chk("post_rst_word", m_log_d[base], 32'h55667788);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
